// File: rtl/uart_echo_pkg.sv
// Shared state encoding and frame constants for the UART echo responder.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int calc_bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_echo_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH; head word is valid combinationally while not empty.
module uart_echo_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_echo_responder.sv
// 8N1 UART loopback peer: received bytes are buffered and retransmitted unchanged.
// tx_hold parks the transmitter so the FIFO fills; bytes arriving while full are dropped.
module uart_echo_responder
  import uart_echo_pkg::*;
#(
  parameter int clk_freq   = 1_000_000,
  parameter int baud_rate  = 9600,
  parameter int fifo_depth = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        tx,
  input  logic        tx_hold,
  output logic        busy,
  output logic        overflow,
  output logic        framing_error,
  output logic [15:0] rx_count
);

  localparam int BIT_CYCLES  = calc_bit_cycles(clk_freq, baud_rate);
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int STOP_CYCLES = STOP_BITS * BIT_CYCLES;
  localparam int CNT_W       = (STOP_CYCLES > 2) ? $clog2(STOP_CYCLES) : 1;
  localparam int IDX_W       = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic [1:0]           rx_sync_q;
  logic                 rx_s;

  uart_state_e          rx_state_q;
  logic [CNT_W-1:0]     rx_cnt_q;
  logic [IDX_W-1:0]     rx_idx_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_armed_q;
  logic                 framing_error_q;

  uart_state_e          tx_state_q;
  logic [CNT_W-1:0]     tx_cnt_q;
  logic [IDX_W-1:0]     tx_idx_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_q;

  logic [15:0]          rx_count_q;
  logic [15:0]          rx_count_d;
  logic                 overflow_q;

  logic                 rx_push_req;
  logic                 rx_accept;
  logic                 rx_drop;
  logic                 tx_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  always_ff @(posedge clk) begin
    if (reset) rx_sync_q <= 2'b11;
    else       rx_sync_q <= {rx_sync_q[0], rx};
  end
  assign rx_s = rx_sync_q[1];

  // Stop-bit sample with a high line: the byte is handed to the FIFO on this edge.
  assign rx_push_req = (rx_state_q == ST_STOP) && (rx_cnt_q == BIT_LAST) && rx_s;
  assign tx_pop      = (tx_state_q == ST_IDLE) && !fifo_empty && !tx_hold;
  assign rx_accept   = rx_push_req && (!fifo_full || tx_pop);
  assign rx_drop     = rx_push_req && fifo_full && !tx_pop;

  uart_echo_fifo #(
    .DEPTH (fifo_depth),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push_req),
    .din   (rx_shift_q),
    .pop   (tx_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q      <= ST_IDLE;
      rx_cnt_q        <= '0;
      rx_idx_q        <= '0;
      rx_shift_q      <= '0;
      rx_armed_q      <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      framing_error_q <= 1'b0;
      case (rx_state_q)
        ST_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_armed_q)  rx_armed_q <= rx_s;
          else if (!rx_s)   rx_state_q <= ST_START;
        end
        ST_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_state_q <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_idx_q == IDX_LAST) rx_state_q <= ST_STOP;
            else                      rx_idx_q   <= rx_idx_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= ST_IDLE;
            // A low stop bit means the line may still be held low; wait for high before re-arming.
            if (!rx_s) begin
              framing_error_q <= 1'b1;
              rx_armed_q      <= 1'b0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_count_d = rx_count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (rx_accept) rx_count_q <= rx_count_d;
      if (rx_drop)   overflow_q <= 1'b1;
    end
  end

  // tx_q follows the state one cycle late; the constant lag keeps every bit exactly BIT_CYCLES wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        ST_IDLE: begin
          tx_q     <= 1'b1;
          tx_cnt_q <= '0;
          if (tx_pop) begin
            tx_shift_q <= fifo_dout;
            tx_state_q <= ST_START;
          end
        end
        ST_START: begin
          tx_q <= 1'b0;
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_state_q <= ST_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          tx_q <= tx_shift_q[0];
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= {1'b0, tx_shift_q[DATA_BITS-1:1]};
            if (tx_idx_q == IDX_LAST) tx_state_q <= ST_STOP;
            else                      tx_idx_q   <= tx_idx_q + 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          tx_q <= 1'b1;
          if (tx_cnt_q == STOP_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= ST_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx            = tx_q;
  assign busy          = !fifo_empty || (tx_state_q != ST_IDLE);
  assign overflow      = overflow_q;
  assign framing_error = framing_error_q;
  assign rx_count      = rx_count_q;

endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

Hardware UART responder that receives 8N1 frames on `rx`, buffers them in a small FIFO, and retransmits each byte unchanged on `tx`. It is the far end of the UART link that the MCU-side UART and the bench `uart_sending` drive. It serves as a synthesizable loopback peer for board bring-up and as a self-checking partner in simulation. Optional flow control (`tx_hold`) lets the bench exercise buffering and overflow.

## Interface
- `clk_freq`, default 1_000_000: system clock frequency in Hz.
- `baud_rate`, default 9600: line rate. Bit period is `BIT_CYCLES = clk_freq / baud_rate`, using integer division (104 at the defaults).
- `fifo_depth`, default 4: FIFO entries. Must be a power of two and ≥ 2.
- `clk`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `rx`, in, 1: serial input, idle high. Asynchronous to `clk`.
- `tx`, out, 1: serial output, idle high.
- `tx_hold`, in, 1: when high, no new TX frame starts. A frame already in progress completes.
- `busy`, out, 1: high while the FIFO is non-empty or a TX frame is in progress.
- `overflow`, out, 1: sticky. Set when a valid byte is dropped because the FIFO is full. Cleared only by reset.
- `framing_error`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `rx_count`, out, 16: number of bytes accepted into the FIFO, wrapping modulo 2^16.

## Operation
- **RX synchronizer:** `rx` passes through a 2-flop synchronizer. All RX decisions use the synchronized value `rx_s`.
- **RX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on the first cycle `rx_s` is 0.
  - START: wait `BIT_CYCLES/2` cycles, then re-sample. If `rx_s` is 1, treat it as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample 8 bits, LSB first, each `BIT_CYCLES` after the previous sample, into a shift register.
  - STOP: sample once after a further `BIT_CYCLES`.
    - `rx_s` = 1: push the byte and go to IDLE.
    - `rx_s` = 0: pulse `framing_error`, discard the byte, go to IDLE. IDLE then re-arms only after `rx_s` has been seen high for 1 cycle.
- **Push rules:**
  - FIFO not full: write the byte and increment `rx_count`.
  - FIFO full: drop the byte, set `overflow`, leave `rx_count` unchanged.
  - Simultaneous push and pop on a full FIFO: the push is accepted.
- **TX FSM states:** IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty and `tx_hold` is 0, pop the head into the TX shift register and go to START.
  - START drives 0 for `BIT_CYCLES`.
  - DATA drives 8 bits, LSB first, `BIT_CYCLES` each.
  - STOP drives 1 for `BIT_CYCLES`, then returns to IDLE. A back-to-back frame may start the next cycle.
- **Empty FIFO:** TX idles with `tx` = 1.
- **Reset:** at any time, including mid-frame, reset returns both FSMs to IDLE, empties the FIFO, and drives `tx` to 1 on the next edge. No partial frame resumes.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `overflow`=0, `framing_error`=0, `rx_count`=0.
- **RX sample points:** relative to the synchronized falling edge of the start bit, sample k (k=0 is the start check) occurs at `BIT_CYCLES/2 + k*BIT_CYCLES` cycles. k=1..8 are data bits; k=9 is the stop bit.
- **Echo latency:** the FIFO write happens on the stop-sample edge. TX IDLE sees non-empty on the next cycle, and `tx` falls exactly 2 cycles after the stop-sample edge, provided TX is idle and `tx_hold`=0.
- **TX frame length:** exactly `10*BIT_CYCLES` cycles, with no jitter.
- **`framing_error`:** high for exactly the cycle after the stop-sample edge.
- **`overflow`:** rises on the cycle after the dropped stop sample.
- **`rx_count` and FIFO occupancy:** both update on the same edge.

## Structure
- **Shared package `uart_echo_pkg`:** holds the FSM state encoding (2-bit IDLE/START/DATA/STOP), the `BIT_CYCLES` computation, and the frame constants (8 data bits, 1 stop bit). Both FSMs reuse the same encoding.
- **Sub-module `uart_echo_fifo`:** synchronous FIFO of `fifo_depth` × 8 bits.
  - Ports: `clk`, `reset`, `push`, `din`, `pop`, `dout`, `full`, `empty`.
  - Uses pointers one bit wider than the address.
  - Head data is valid combinationally while `empty`=0.
- **Top level:** the RX and TX FSMs stay in the top module.

## Test plan
- **Single echo:** send 0x55 at defaults.
  - `tx` falls 2 cycles after the stop sample.
  - Echoed frame bits are 0,1,0,1,0,1,0,1,0,1, each 104 cycles.
  - `rx_count`=1, `busy` returns to 0.
- **Glitch:** drive `rx` low for 20 cycles.
  - No push, `rx_count` stays 0, `tx` stays 1, and a following 0xA5 echoes correctly.
- **Framing error:** send 0xA3 with the stop bit held low.
  - `framing_error` pulses for 1 cycle, nothing is echoed, `rx_count` is unchanged.
- **Overflow:** hold `tx_hold`=1 and send 0x01..0x06 back-to-back.
  - `overflow` sets after the 5th byte and `rx_count`=4.
  - Release `tx_hold`: exactly 0x01, 0x02, 0x03, 0x04 are echoed, back-to-back.
- **Reset mid-frame:** assert `reset` for 1 cycle during echoed bit 3 of 0xF0.
  - `tx`=1 on the next edge, FIFO is empty, `rx_count`=0, and no further TX activity occurs.
- **Counter wrap:** preload via 65,536 accepted bytes, or force `rx_count`=16'hFFFF, then send 1 byte.
  - `rx_count` reads 0x0000 and the byte is still echoed.
